// File: rtl/cpu_mult_pkg.sv
// Shared types and mode helpers for the pipelined M-stage multiplier.
// Mode encoding selects which product word is returned and operand signedness.
package cpu_mult_pkg;

   typedef logic [1:0] mult_mode_t;

   localparam mult_mode_t MODE_MUL    = 2'd0;
   localparam mult_mode_t MODE_MULXSS = 2'd1;
   localparam mult_mode_t MODE_MULXSU = 2'd2;
   localparam mult_mode_t MODE_MULXUU = 2'd3;

   function automatic logic is_signed_a(mult_mode_t mode);
      return (mode == MODE_MULXSS) || (mode == MODE_MULXSU);
   endfunction

   function automatic logic is_signed_b(mult_mode_t mode);
      return mode == MODE_MULXSS;
   endfunction

endpackage

// File: rtl/cpu_mult_pipe_if.sv
// Operand/result handshake bundle for cpu_mult_pipe.
// The slave side is the multiplier, the master side is the issuing stage.
interface cpu_mult_pipe_if
   import cpu_mult_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 5
);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_src1;
   logic [DATA_W-1:0] in_src2;
   mult_mode_t        in_mode;
   logic [TAG_W-1:0]  in_tag;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_result;
   logic [TAG_W-1:0]  out_tag;

   modport master (
      output in_valid, in_src1, in_src2, in_mode, in_tag, out_ready,
      input  in_ready, out_valid, out_result, out_tag
   );

   modport slave (
      input  in_valid, in_src1, in_src2, in_mode, in_tag, out_ready,
      output in_ready, out_valid, out_result, out_tag
   );

endinterface

// File: rtl/cpu_mult_slice.sv
// One SLICE_W x SLICE_W unsigned multiply with a registered, enabled output.
// Sized to map onto a single DSP block.
module cpu_mult_slice #(
   parameter int SLICE_W = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic [SLICE_W-1:0]   a,
   input  logic [SLICE_W-1:0]   b,
   output logic [2*SLICE_W-1:0] p
);

   logic [2*SLICE_W-1:0] a_ext;
   logic [2*SLICE_W-1:0] b_ext;

   assign a_ext = {{SLICE_W{1'b0}}, a};
   assign b_ext = {{SLICE_W{1'b0}}, b};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p <= '0;
      end else if (en) begin
         p <= a_ext * b_ext;
      end
   end

endmodule

// File: rtl/cpu_mult_pipe.sv
// Three-stage pipelined multiplier: operand regs, slice products, sum/correct/select.
// Whole pipe stalls on a held output; flush kills every in-flight op.
module cpu_mult_pipe
   import cpu_mult_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int SLICE_W = 16,
   parameter int TAG_W   = 5
) (
   input logic            clk,
   input logic            reset,
   input logic            flush,
   cpu_mult_pipe_if.slave bus
);

   localparam int NS = DATA_W / SLICE_W;

   if (DATA_W % SLICE_W != 0) begin : g_bad_w
      $error("DATA_W must be a multiple of SLICE_W");
   end

   logic              advance;
   logic              v1, v2, vo;
   logic [DATA_W-1:0] a1, b1, a2, b2;
   mult_mode_t        m1, m2;
   logic [TAG_W-1:0]  t1, t2;
   logic [DATA_W-1:0] res_q;
   logic [TAG_W-1:0]  tag_q;
   logic [DATA_W-1:0] res_d;
   logic [DATA_W-1:0] hi;
   logic [2*DATA_W-1:0] full;
   logic [2*SLICE_W-1:0] prod [NS*NS];

   assign advance        = ~vo | bus.out_ready;
   assign bus.in_ready   = advance;
   assign bus.out_valid  = vo;
   assign bus.out_result = res_q;
   assign bus.out_tag    = tag_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         vo <= 1'b0;
      end else if (flush) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         vo <= 1'b0;
      end else if (advance) begin
         v1 <= bus.in_valid;
         v2 <= v1;
         vo <= v2;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a1    <= '0;
         b1    <= '0;
         m1    <= MODE_MUL;
         t1    <= '0;
         a2    <= '0;
         b2    <= '0;
         m2    <= MODE_MUL;
         t2    <= '0;
         res_q <= '0;
         tag_q <= '0;
      end else if (advance) begin
         a1    <= bus.in_src1;
         b1    <= bus.in_src2;
         m1    <= bus.in_mode;
         t1    <= bus.in_tag;
         a2    <= a1;
         b2    <= b1;
         m2    <= m1;
         t2    <= t1;
         res_q <= res_d;
         tag_q <= t2;
      end
   end

   for (genvar i = 0; i < NS; i++) begin : g_row
      for (genvar j = 0; j < NS; j++) begin : g_col
         cpu_mult_slice #(
            .SLICE_W(SLICE_W)
         ) u_slice (
            .clk  (clk),
            .reset(reset),
            .en   (advance),
            .a    (a1[i*SLICE_W +: SLICE_W]),
            .b    (b1[j*SLICE_W +: SLICE_W]),
            .p    (prod[i*NS+j])
         );
      end
   end

   // Unsigned product, then two's-complement fixup on the high word only
   always_comb begin
      full = '0;
      for (int i = 0; i < NS; i++) begin
         for (int j = 0; j < NS; j++) begin
            full = full + ((2*DATA_W)'(prod[i*NS+j]) << ((i + j) * SLICE_W));
         end
      end
      hi = full[2*DATA_W-1:DATA_W];
      if (is_signed_a(m2) && a2[DATA_W-1]) begin
         hi = hi - b2;
      end
      if (is_signed_b(m2) && b2[DATA_W-1]) begin
         hi = hi - a2;
      end
      res_d = (m2 == MODE_MUL) ? full[DATA_W-1:0] : hi;
   end

endmodule

// File: tb/tb_cpu_mult_pipe.sv
// Scoreboard bench for cpu_mult_pipe at 32/16 and 64/16 geometries.
// Expected words come from constants or a wide-integer reference product.
module tb_cpu_mult_pipe;
   import cpu_mult_pkg::*;

   typedef struct {
      logic [63:0] res;
      logic [4:0]  tag;
      int          acc;
      bit          lat;
   } sb_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic flush = 1'b0;

   always #5 clk = ~clk;

   cpu_mult_pipe_if #(.DATA_W(32), .TAG_W(5)) bus32 ();
   cpu_mult_pipe_if #(.DATA_W(64), .TAG_W(5)) bus64 ();

   cpu_mult_pipe #(.DATA_W(32), .SLICE_W(16), .TAG_W(5)) dut32 (
      .clk(clk), .reset(reset), .flush(flush), .bus(bus32)
   );

   cpu_mult_pipe #(.DATA_W(64), .SLICE_W(16), .TAG_W(5)) dut64 (
      .clk(clk), .reset(reset), .flush(1'b0), .bus(bus64)
   );

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   sb_t q[2][$];
   sb_t pend[2];
   bit hold[2];
   logic [63:0] hres[2];
   logic [4:0] htag[2];
   int n_out[2];
   bit rnd32 = 1'b0;
   logic rdy32 = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #2;
      bus32.out_ready = rnd32 ? ($urandom_range(0, 3) != 0) : rdy32;
      bus64.out_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] ref_mul(int w, logic [63:0] a,
                                           logic [63:0] b, logic [1:0] mode);
      logic [127:0] m, ea, eb, p;
      m  = (128'd1 << w) - 128'd1;
      ea = {64'd0, a} & m;
      eb = {64'd0, b} & m;
      if ((mode == 2'd1 || mode == 2'd2) && a[w-1]) ea = ea | ~m;
      if (mode == 2'd1 && b[w-1]) eb = eb | ~m;
      p = ea * eb;
      if (mode == 2'd0) p = p & m;
      else p = (p >> w) & m;
      return p[63:0];
   endfunction

   function automatic logic [31:0] rnd_word();
      case ($urandom_range(0, 7))
         0: return 32'hFFFF_FFFF;
         1: return 32'h8000_0000;
         2: return 32'h0;
         default: return $urandom;
      endcase
   endfunction

   task automatic mon(int id, logic rs, logic fl, logic iv, logic ir,
                      logic ov, logic ordy, logic [63:0] res, logic [4:0] tag);
      sb_t e;
      if (rs) begin
         q[id].delete();
         hold[id] = 1'b0;
      end else begin
         if (ov) begin
            if (hold[id]) begin
               chk("held_result", res, hres[id]);
               chk("held_tag", {59'd0, tag}, {59'd0, htag[id]});
            end
            if (!ordy) begin
               chk("stall_in_ready", {63'd0, ir}, 64'd0);
            end else if (q[id].size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_out dut%0d: got 0x%0h tag %0d, want no output",
                        id, res, tag);
            end else begin
               e = q[id].pop_front();
               n_out[id]++;
               chk("result", res, e.res);
               chk("tag", {59'd0, tag}, {59'd0, e.tag});
               if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd3);
            end
         end
         hold[id] = ov & ~ordy;
         hres[id] = res;
         htag[id] = tag;
         if (fl) begin
            q[id].delete();
         end else if (iv & ir) begin
            e = pend[id];
            e.acc = cyc;
            q[id].push_back(e);
         end
      end
   endtask

   always @(negedge clk)
      mon(0, reset, flush, bus32.in_valid, bus32.in_ready, bus32.out_valid,
          bus32.out_ready, {32'd0, bus32.out_result}, bus32.out_tag);

   always @(negedge clk)
      mon(1, reset, 1'b0, bus64.in_valid, bus64.in_ready, bus64.out_valid,
          bus64.out_ready, bus64.out_result, bus64.out_tag);

   task automatic cycles(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic issue32(logic [31:0] a, logic [31:0] b, logic [1:0] mode,
                          logic [4:0] tag, bit use_exp, logic [31:0] expv, bit lat);
      pend[0].res = use_exp ? {32'd0, expv} : ref_mul(32, {32'd0, a}, {32'd0, b}, mode);
      pend[0].tag = tag;
      pend[0].lat = lat;
      bus32.in_src1  = a;
      bus32.in_src2  = b;
      bus32.in_mode  = mode;
      bus32.in_tag   = tag;
      bus32.in_valid = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         if (bus32.in_ready) break;
         if (n == 999) begin
            compared++;
            mismatched++;
            $display("FAIL accept_timeout dut0: in_ready stuck at 0, want 1");
         end
      end
      @(posedge clk);
      #1;
      bus32.in_valid = 1'b0;
   endtask

   task automatic issue64(logic [63:0] a, logic [63:0] b, logic [1:0] mode,
                          logic [4:0] tag);
      pend[1].res = ref_mul(64, a, b, mode);
      pend[1].tag = tag;
      pend[1].lat = 1'b0;
      bus64.in_src1  = a;
      bus64.in_src2  = b;
      bus64.in_mode  = mode;
      bus64.in_tag   = tag;
      bus64.in_valid = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         if (bus64.in_ready) break;
         if (n == 999) begin
            compared++;
            mismatched++;
            $display("FAIL accept_timeout dut1: in_ready stuck at 0, want 1");
         end
      end
      @(posedge clk);
      #1;
      bus64.in_valid = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nv;
      int base;
      bus32.in_valid = 1'b0;
      bus32.in_src1  = '0;
      bus32.in_src2  = '0;
      bus32.in_mode  = MODE_MUL;
      bus32.in_tag   = '0;
      bus64.in_valid = 1'b0;
      bus64.in_src1  = '0;
      bus64.in_src2  = '0;
      bus64.in_mode  = MODE_MUL;
      bus64.in_tag   = '0;

      cycles(3);
      chk("reset_out_valid", {63'd0, bus32.out_valid}, 64'd0);
      chk("reset_out_result", {32'd0, bus32.out_result}, 64'd0);
      chk("reset_out_tag", {59'd0, bus32.out_tag}, 64'd0);
      chk("reset_in_ready", {63'd0, bus32.in_ready}, 64'd1);
      reset = 1'b0;
      cycles(2);

      issue32(32'h3, 32'h5, MODE_MUL, 5'd1, 1'b1, 32'hF, 1'b1);
      cycles(4);

      issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, MODE_MULXUU, 5'd2, 1'b1, 32'hFFFF_FFFE, 1'b1);
      issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, MODE_MULXSS, 5'd3, 1'b1, 32'h0, 1'b1);
      issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, MODE_MUL, 5'd4, 1'b1, 32'h1, 1'b1);
      issue32(32'hFFFF_FFFF, 32'h2, MODE_MULXSU, 5'd5, 1'b1, 32'hFFFF_FFFF, 1'b1);
      cycles(5);

      base = n_out[0];
      fork
         for (int t = 0; t < 8; t++)
            issue32($urandom, $urandom, 2'($urandom_range(0, 3)), 5'(t), 1'b0, 32'd0, 1'b0);
         begin
            cycles(5);
            rdy32 = 1'b0;
            cycles(4);
            rdy32 = 1'b1;
         end
      join
      cycles(8);
      chk("stream_count", 64'(n_out[0] - base), 64'd8);
      chk("stream_drained", 64'(q[0].size()), 64'd0);

      issue32(32'h7, 32'h9, MODE_MUL, 5'd10, 1'b1, 32'd63, 1'b0);
      issue32(32'h11, 32'h3, MODE_MUL, 5'd11, 1'b0, 32'd0, 1'b0);
      issue32(32'h12, 32'h3, MODE_MUL, 5'd12, 1'b0, 32'd0, 1'b0);
      pend[0].res = 64'd1;
      pend[0].tag = 5'd13;
      pend[0].lat = 1'b0;
      bus32.in_src1  = 32'h1;
      bus32.in_src2  = 32'h1;
      bus32.in_mode  = MODE_MUL;
      bus32.in_tag   = 5'd13;
      bus32.in_valid = 1'b1;
      flush = 1'b1;
      cycles(1);
      flush = 1'b0;
      bus32.in_valid = 1'b0;
      nv = 0;
      repeat (6) begin
         @(negedge clk);
         nv += int'(bus32.out_valid);
      end
      chk("flush_no_out", 64'(nv), 64'd0);
      @(posedge clk);
      #1;
      issue32(32'h1234, 32'h10, MODE_MUL, 5'd14, 1'b1, 32'h12340, 1'b1);
      cycles(5);
      chk("flush_drained", 64'(q[0].size()), 64'd0);

      rdy32 = 1'b0;
      issue32(32'hABCD, 32'h2, MODE_MUL, 5'd20, 1'b0, 32'd0, 1'b0);
      issue32(32'hBCDE, 32'h3, MODE_MUL, 5'd21, 1'b0, 32'd0, 1'b0);
      cycles(2);
      chk("pre_reset_valid", {63'd0, bus32.out_valid}, 64'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("async_reset_valid", {63'd0, bus32.out_valid}, 64'd0);
      chk("async_reset_result", {32'd0, bus32.out_result}, 64'd0);
      cycles(2);
      reset = 1'b0;
      rdy32 = 1'b1;
      cycles(10);
      chk("post_reset_in_ready", {63'd0, bus32.in_ready}, 64'd1);

      rnd32 = 1'b1;
      fork
         for (int k = 0; k < 10000; k++) begin
            if ($urandom_range(0, 7) == 0) cycles(1);
            issue32(rnd_word(), rnd_word(), 2'($urandom_range(0, 3)),
                    5'($urandom), 1'b0, 32'd0, 1'b0);
         end
         for (int k = 0; k < 10000; k++) begin
            if ($urandom_range(0, 7) == 0) cycles(1);
            issue64({rnd_word(), rnd_word()}, {rnd_word(), rnd_word()},
                    2'($urandom_range(0, 3)), 5'($urandom));
         end
      join
      rnd32 = 1'b0;
      rdy32 = 1'b1;
      cycles(40);
      chk("random32_drained", 64'(q[0].size()), 64'd0);
      chk("random64_drained", 64'(q[1].size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
